// File: rtl/gpr_pkg.sv
// Shared defaults and types for the general-purpose register file writeback path.
package gpr_pkg;

    localparam int GPR_DATA_W      = 16;
    localparam int GPR_ADDR_W      = 3;
    localparam int GPR_NUM_REGS    = 8;
    localparam int GPR_NUM_REQ_DEF = 3;
    localparam int GPR_MAX_REQ     = 8;

    // Wide enough to index any legal requester count.
    typedef logic [$clog2(GPR_MAX_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority grant: first asserted request at or after ptr,
// wrapping modulo N, gets a one-hot grant.
module rr_grant
    import gpr_pkg::*;
#(
    parameter int N = GPR_NUM_REQ_DEF
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    output logic [N-1:0] gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // Walking from the farthest offset back to ptr leaves the nearest requester
    // as the final winner, which is the rotate/encode/unrotate result.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port.
// Define GPR_WB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ  = GPR_NUM_REQ_DEF,
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int NUM_REGS = GPR_NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      reg_write_en,
    output logic [ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]         reg_write_data,
    output logic [NUM_REGS-1:0]       pending_mask,
    output logic                      dest_err
);

    // Handshake: requester i is accepted at a rising edge where
    // req_valid[i] & req_ready[i]; dest/data must stay stable until then.

    logic [NUM_REQ-1:0]  gnt_raw;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic                legal;
    req_idx_t            sel_idx;
    logic [ADDR_W-1:0]   sel_dest;
    logic [DATA_W-1:0]   sel_data;
    req_idx_t            grant_ptr;

    logic                wr_en_d, wr_en_q;
    logic [ADDR_W-1:0]   wr_dest_d, wr_dest_q;
    logic [DATA_W-1:0]   wr_data_d, wr_data_q;
    logic [NUM_REGS-1:0] pending_d, pending_q;
    logic                err_d, err_q;

`ifdef GPR_WB_FIXED_PRIO_EN
    assign grant_ptr = '0;
`else
    req_idx_t rr_ptr_d, rr_ptr_q;

    assign grant_ptr = rr_ptr_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = req_idx_t'((int'(sel_idx) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    rr_grant #(
        .N (NUM_REQ)
    ) u_rr_grant (
        .req (req_valid),
        .ptr (grant_ptr),
        .gnt (gnt_raw)
    );

    // No grant may be seen while reset is held, so nothing is consumed then.
    assign grant     = rst ? '0 : gnt_raw;
    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_idx  = '0;
        sel_dest = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = req_idx_t'(i);
                sel_dest = req_dest[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign legal = int'(sel_dest) < NUM_REGS;

    // Illegal destinations are consumed but leave dest/data holding their old values.
    always_comb begin
        wr_en_d   = accept & legal;
        err_d     = accept & ~legal;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        pending_d = '0;
        if (accept && legal) begin
            wr_dest_d = sel_dest;
            wr_data_d = sel_data;
            pending_d = NUM_REGS'(1) << sel_dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign pending_mask   = pending_q;
    assign dest_err       = err_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: default instance plus a NUM_REGS=6 instance
// for illegal destinations. Expectations follow GPR_WB_FIXED_PRIO_EN when defined.
module tb_gpr_wb_arbiter;

    logic        clk;
    logic        rst;

    logic [2:0]  req_valid;
    logic [8:0]  req_dest;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  pending_mask;
    logic        dest_err;

    logic [2:0]  v6;
    logic [8:0]  d6;
    logic [47:0] dat6;
    logic [2:0]  r6;
    logic        en6;
    logic [2:0]  wd6;
    logic [15:0] wdat6;
    logic [5:0]  pend6;
    logic        err6;

    logic [15:0] rf [8];
    logic [18:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    gpr_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pending_mask   (pending_mask),
        .dest_err       (dest_err)
    );

    gpr_wb_arbiter #(.NUM_REGS(6)) dut6 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (v6),
        .req_dest       (d6),
        .req_data       (dat6),
        .req_ready      (r6),
        .reg_write_en   (en6),
        .reg_write_dest (wd6),
        .reg_write_data (wdat6),
        .pending_mask   (pend6),
        .dest_err       (err6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model fed by the write port
    always @(posedge clk) begin
        if (reg_write_en) rf[reg_write_dest] <= reg_write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  dst_tab [3];
        logic [15:0] dat_tab [3];
        logic [18:0] exp_w;
        int g;
        bit fixed_prio;

`ifdef GPR_WB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        dst_tab = '{3'd1, 3'd2, 3'd4};
        dat_tab = '{16'h1111, 16'h2222, 16'h4444};
        for (int r = 0; r < 8; r++) rf[r] = '0;

        rst = 1'b1;
        req_valid = 3'b111;
        req_dest = '0;
        req_data = '0;
        v6 = '0;
        d6 = '0;
        dat6 = '0;

        // reset state, no grant while reset held
        #2;
        check("rst_ready", req_ready, 3'b000);
        check("rst_en", reg_write_en, 1'b0);
        check("rst_dest", reg_write_dest, 3'd0);
        check("rst_data", reg_write_data, 16'h0);
        check("rst_pend", pending_mask, 8'h00);
        check("rst_err", dest_err, 1'b0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // single requester 1: dest 5, data BEEF
        req_valid = 3'b010;
        req_dest  = {3'd0, 3'd5, 3'd0};
        req_data  = {16'h0, 16'hBEEF, 16'h0};
        #1;
        check("single_ready", req_ready, 3'b010);
        cyc();
        req_valid = 3'b000;
        check("single_en", reg_write_en, 1'b1);
        check("single_dest", reg_write_dest, 3'd5);
        check("single_data", reg_write_data, 16'hBEEF);
        check("single_pend", pending_mask, 8'b0010_0000);
        check("single_err", dest_err, 1'b0);
        cyc();
        check("idle_en", reg_write_en, 1'b0);
        check("idle_hold_dest", reg_write_dest, 3'd5);
        check("idle_hold_data", reg_write_data, 16'hBEEF);
        check("idle_pend", pending_mask, 8'h00);

        // wrap: pointer at 2, requesters 0 and 1 valid
        req_valid = 3'b011;
        req_dest  = {dst_tab[2], dst_tab[1], dst_tab[0]};
        req_data  = {dat_tab[2], dat_tab[1], dat_tab[0]};
        #1;
        check("wrap_ready", req_ready, 3'b001);
        cyc();
        check("wrap_dest", reg_write_dest, 3'd1);
        check("wrap_data", reg_write_data, 16'h1111);
        check("wrap_next_ready", req_ready, fixed_prio ? 3'b001 : 3'b010);
        cyc();
        check("wrap_next_dest", reg_write_dest, fixed_prio ? 3'd1 : 3'd2);
        check("wrap_next_en", reg_write_en, 1'b1);

        // reset mid-stream with a write in flight
        rst = 1'b1;
        #1;
        check("mid_rst_en", reg_write_en, 1'b0);
        check("mid_rst_dest", reg_write_dest, 3'd0);
        check("mid_rst_data", reg_write_data, 16'h0);
        check("mid_rst_pend", pending_mask, 8'h00);
        check("mid_rst_ready", req_ready, 3'b000);
        rst = 1'b0;

        // fairness: all valid for 6 cycles
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            g = fixed_prio ? 0 : (k % 3);
            #1;
            check($sformatf("fair_ready_%0d", k), req_ready, 3'b001 << g);
            exp_q.push_back({dst_tab[g], dat_tab[g]});
            cyc();
            exp_w = exp_q.pop_front();
            check($sformatf("fair_en_%0d", k), reg_write_en, 1'b1);
            check($sformatf("fair_wr_%0d", k), {reg_write_dest, reg_write_data}, exp_w);
        end
        req_valid = 3'b000;
        #1;
        check("fair_drop_ready", req_ready, 3'b000);
        cyc();
        check("fair_drop_en", reg_write_en, 1'b0);

        // same register written by two requesters back to back
        req_valid = 3'b001;
        req_dest  = {3'd0, 3'd0, 3'd3};
        req_data  = {16'h0, 16'h0002, 16'h0001};
        #1;
        check("same0_ready", req_ready, 3'b001);
        cyc();
        check("same0_data", reg_write_data, 16'h0001);
        check("same0_pend", pending_mask, 8'h08);
        req_valid = 3'b010;
        req_dest  = {3'd0, 3'd3, 3'd3};
        #1;
        check("same1_ready", req_ready, 3'b010);
        cyc();
        check("same1_data", reg_write_data, 16'h0002);
        check("same1_pend", pending_mask, 8'h08);
        req_valid = 3'b000;
        cyc();
        check("same_rf_r3", rf[3], 16'h0002);

        // illegal destination on the NUM_REGS=6 instance
        v6   = 3'b001;
        d6   = {3'd0, 3'd0, 3'd7};
        dat6 = {16'h0, 16'h0, 16'hABCD};
        #1;
        check("ill_ready", r6, 3'b001);
        cyc();
        v6 = 3'b000;
        check("ill_en", en6, 1'b0);
        check("ill_err", err6, 1'b1);
        check("ill_pend", pend6, 6'b000000);
        cyc();
        check("ill_err_pulse", err6, 1'b0);
        check("ill_en_idle", en6, 1'b0);
        v6   = 3'b011;
        d6   = {3'd0, 3'd5, 3'd3};
        dat6 = {16'h0, 16'h5555, 16'h3333};
        #1;
        check("ill_adv_ready", r6, fixed_prio ? 3'b001 : 3'b010);
        cyc();
        v6 = 3'b000;
        check("ill_adv_en", en6, 1'b1);
        check("ill_adv_pend", pend6, fixed_prio ? 6'b001000 : 6'b100000);
        check("ill_adv_data", wdat6, fixed_prio ? 16'h3333 : 16'h5555);
        check("ill_adv_err", err6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single write port of the 16-bit general-purpose register file among NUM_REQ writeback sources, such as the ALU, the load unit and immediate/move.
- Each source uses a valid/ready handshake. Selection is round-robin and one write is issued per cycle.
- The selected write passes through a single output register that drives reg_write_en, reg_write_dest and reg_write_data.
- A per-register pending mask tells the decode stage which destination has a write in flight.

Parameters:
- NUM_REQ, 3: number of writeback requesters, legal range 2..8.
- DATA_W, 16: register data width.
- ADDR_W, 3: register address width.
- NUM_REGS, 8: number of implemented registers. Destinations >= NUM_REGS are illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_dest  input  NUM_REQ*ADDR_W  packed destinations; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing as req_dest.
- req_ready  output  NUM_REQ  one-hot grant; asserted in the cycle a request is accepted.
- reg_write_en  output  1  register-file write enable.
- reg_write_dest  output  ADDR_W  register-file write address.
- reg_write_data  output  DATA_W  register-file write data.
- pending_mask  output  NUM_REGS  bit r = 1 when a write to register r is held in the output stage.
- dest_err  output  1  one-cycle pulse when an illegal destination is accepted and dropped.

Behaviour:
- Reset, asynchronous and applied immediately:
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0, pending_mask=0, dest_err=0.
  - Round-robin pointer rr_ptr=0.
- Grant is combinational:
  - Search starts at rr_ptr and wraps modulo NUM_REQ. The first requester with req_valid=1 is granted.
  - req_ready is one-hot, or all zero when there is no valid request.
  - req_ready is never asserted while rst=1.
- Acceptance occurs when req_valid[i] & req_ready[i] at a rising edge.
- Latency is 1 cycle. A request accepted at edge N drives reg_write_en=1 with its dest/data through cycle N+1, so the register file writes at edge N+1.
- The output stage always drains, because the register file never stalls. Back-to-back accepts therefore give one write per cycle, with no bubbles.
- Pointer update:
  - After an accept from requester i, rr_ptr = (i+1) mod NUM_REQ.
  - With no accept, rr_ptr holds.
  - A requester holding valid is guaranteed a grant within NUM_REQ cycles.
- Requester obligation: once req_valid is asserted, req_dest and req_data stay stable until accepted. The arbiter does not check this.
- Illegal destination (req_dest >= NUM_REGS):
  - The request is accepted (ready=1) so the requester does not hang.
  - reg_write_en stays 0 the next cycle and dest_err pulses 1 for that cycle.
  - rr_ptr still advances.
- pending_mask = one-hot of reg_write_dest when reg_write_en=1, else 0. It is registered together with the output stage.
- If two requesters target the same register in consecutive cycles, the later one wins, matching the order of writes to the register file.
- Reset asserted mid-operation: the in-flight write is discarded (reg_write_en forced 0) and no grant is issued until rst is released. The first edge after release can accept.
- With no requests, reg_write_en=0 and the data/dest outputs hold their last values.

Optional Feature:
- Macro GPR_WB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. rr_ptr is not implemented.
- When undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package gpr_pkg holds:
  - DATA_W / ADDR_W / NUM_REGS defaults.
  - The requester-index typedef.
  - A localparam for the default requester count.
- One natural sub-module, rr_grant: a combinational rotate–priority-encode–unrotate circuit.
  - Inputs: request vector and pointer.
  - Output: one-hot grant.
  - Reused by later bus arbiters.

Test Plan:
- Reset: drive rst=1 mid-stream while reg_write_en=1 -> all outputs 0 immediately; rr_ptr=0 after release.
- Single requester: req_valid[1]=1, dest=5, data=16'hBEEF -> req_ready[1]=1 same cycle; next cycle reg_write_en=1, dest=5, data=BEEF, pending_mask=8'b0010_0000.
- Fairness: all three requesters valid continuously for 6 cycles -> grants 0,1,2,0,1,2; reg_write_en high for 6 consecutive cycles. With GPR_WB_FIXED_PRIO_EN -> grants 0 every cycle.
- Wrap: rr_ptr=2 with req_valid=3'b011 -> requester 0 granted, rr_ptr becomes 1.
- Illegal destination: NUM_REGS=6, dest=7 -> ready=1, next cycle reg_write_en=0 and dest_err=1 for exactly one cycle.
- Same-register ordering: requester 0 writes R3=1, then requester 1 writes R3=2 on the next cycle -> the register file reads R3=2 afterwards.
